// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_stage_skid pipeline register.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

    localparam int MEMWB_W    = 97;
    localparam int PIPE_CNT_W = 2;

    function automatic logic [PIPE_CNT_W-1:0] state_count(pipe_state_t s);
        case (s)
            ST_FULL: return PIPE_CNT_W'(1);
            ST_SKID: return PIPE_CNT_W'(2);
            default: return PIPE_CNT_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream and downstream valid/ready handshake of one pipeline stage.
// master = surrounding pipeline (producer + consumer), slave = the stage.
interface pipe_stage_skid_if #(parameter int DATA_W = pipe_pkg::MEMWB_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and synchronous clear (clear wins).
// One-cycle load latency; no handshake of its own.
module pipe_data_reg #(
    parameter int DATA_W = pipe_pkg::MEMWB_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register, one-cycle latency, full throughput under out_ready=1.
// SKID=1: two entries, in_ready from a flop; SKID=0: one entry, in_ready = ~out_valid | out_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = MEMWB_W,
    parameter int SKID   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    pipe_stage_skid_if.slave      bus,
    output logic [PIPE_CNT_W-1:0] count
);

    pipe_state_t           state, state_nxt;
    logic                  in_xfer, out_xfer;
    logic                  main_ld, main_from_skid;
    logic                  out_valid_q;
    logic [PIPE_CNT_W-1:0] count_q;
    logic [DATA_W-1:0]     main_q, main_d, skid_q;

    assign in_xfer  = bus.in_valid & bus.in_ready;
    assign out_xfer = out_valid_q & bus.out_ready;

    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_nxt = ST_FULL;
                    main_ld   = 1'b1;
                end
            end
            ST_FULL: begin
                if (in_xfer && out_xfer) begin
                    main_ld = 1'b1;
                end else if (in_xfer) begin
                    state_nxt = ST_SKID;
                end else if (out_xfer) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_xfer) begin
                    state_nxt      = ST_FULL;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Flush drops whatever would have been loaded this edge.
        if (flush) begin
            state_nxt      = ST_EMPTY;
            main_ld        = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state       <= state_nxt;
            out_valid_q <= (state_nxt != ST_EMPTY);
            count_q     <= state_count(state_nxt);
        end
    end

    assign main_d = main_from_skid ? skid_q : bus.in_data;

    pipe_data_reg #(.DATA_W(DATA_W)) u_main (
        .clk (clk),
        .clr (reset),
        .ld  (main_ld),
        .d   (main_d),
        .q   (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;
            logic skid_ld;

            // Only a FULL-state accept with no departure parks data in the skid slot.
            assign skid_ld = (state == ST_FULL) & in_xfer & ~out_xfer & ~flush;

            pipe_data_reg #(.DATA_W(DATA_W)) u_skid (
                .clk (clk),
                .clr (reset),
                .ld  (skid_ld),
                .d   (bus.in_data),
                .q   (skid_q)
            );

            always_ff @(posedge clk) begin
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_nxt != ST_SKID);
                end
            end

            assign bus.in_ready = in_ready_q;
        end else begin : g_noskid
            assign skid_q       = '0;
            assign bus.in_ready = ~out_valid_q | bus.out_ready;
        end
    endgenerate

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign count         = count_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances (SKID=1/97b, SKID=0/97b, SKID=1/1b) against a queue model.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    typedef logic [MEMWB_W-1:0] word_t;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_skid_if #(.DATA_W(MEMWB_W)) i0 ();
    pipe_stage_skid_if #(.DATA_W(MEMWB_W)) i1 ();
    pipe_stage_skid_if #(.DATA_W(1))       i2 ();
    logic [PIPE_CNT_W-1:0] cnt0, cnt1, cnt2;

    pipe_stage_skid #(.DATA_W(MEMWB_W), .SKID(1)) u_skid97 (
        .clk(clk), .reset(rst), .flush(flush), .bus(i0), .count(cnt0));
    pipe_stage_skid #(.DATA_W(MEMWB_W), .SKID(0)) u_noskid97 (
        .clk(clk), .reset(rst), .flush(flush), .bus(i1), .count(cnt1));
    pipe_stage_skid #(.DATA_W(1), .SKID(1)) u_skid1 (
        .clk(clk), .reset(rst), .flush(flush), .bus(i2), .count(cnt2));

    int    checks = 0;
    int    errors = 0;
    word_t mq[ND][$];
    bit    is_skid[ND];
    word_t mask[ND];
    logic  d_iv[ND];
    logic  d_or[ND];
    word_t d_dat[ND];
    logic  o_ir[ND];
    logic  o_ov[ND];
    word_t o_od[ND];
    logic [PIPE_CNT_W-1:0] o_cnt[ND];

    assign o_ir[0] = i0.in_ready;  assign o_ov[0] = i0.out_valid;
    assign o_od[0] = i0.out_data;  assign o_cnt[0] = cnt0;
    assign o_ir[1] = i1.in_ready;  assign o_ov[1] = i1.out_valid;
    assign o_od[1] = i1.out_data;  assign o_cnt[1] = cnt1;
    assign o_ir[2] = i2.in_ready;  assign o_ov[2] = i2.out_valid;
    assign o_od[2] = {{(MEMWB_W-1){1'b0}}, i2.out_data};
    assign o_cnt[2] = cnt2;

    task automatic check_val(string tag, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: stage is a FIFO of capacity 2 (SKID=1) or 1 with pass-through refill (SKID=0).
    function automatic logic exp_ready(int d);
        if (is_skid[d]) return (mq[d].size() < 2);
        return (mq[d].size() == 0) || d_or[d];
    endfunction

    task automatic drive(int d, logic iv, word_t dat, logic ordy);
        d_iv[d]  = iv;
        d_dat[d] = dat;
        d_or[d]  = ordy;
        case (d)
            0: begin i0.in_valid = iv; i0.in_data = dat; i0.out_ready = ordy; end
            1: begin i1.in_valid = iv; i1.in_data = dat; i1.out_ready = ordy; end
            default: begin i2.in_valid = iv; i2.in_data = dat[0]; i2.out_ready = ordy; end
        endcase
    endtask

    task automatic idle_all();
        for (int d = 0; d < ND; d++) drive(d, 1'b0, '0, 1'b1);
    endtask

    task automatic check_all(string tag);
        for (int d = 0; d < ND; d++) begin
            check_val($sformatf("%s.d%0d.in_ready", tag, d), 128'(o_ir[d]), 128'(exp_ready(d)));
            check_val($sformatf("%s.d%0d.out_valid", tag, d), 128'(o_ov[d]), 128'(mq[d].size() > 0));
            check_val($sformatf("%s.d%0d.count", tag, d), 128'(o_cnt[d]), 128'(mq[d].size()));
            if (mq[d].size() > 0)
                check_val($sformatf("%s.d%0d.out_data", tag, d), 128'(o_od[d]), 128'(mq[d][0]));
        end
    endtask

    task automatic step(string tag);
        bit acc_in[ND];
        bit acc_out[ND];
        #1;
        check_all(tag);
        for (int d = 0; d < ND; d++) begin
            acc_in[d]  = d_iv[d] && exp_ready(d);
            acc_out[d] = (mq[d].size() > 0) && d_or[d];
        end
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            if (rst || flush) begin
                mq[d].delete();
            end else begin
                if (acc_out[d]) void'(mq[d].pop_front());
                if (acc_in[d]) mq[d].push_back(d_dat[d] & mask[d]);
            end
        end
        #1;
    endtask

    task automatic check_reset_vals(string tag);
        for (int d = 0; d < ND; d++)
            check_val($sformatf("%s.d%0d.out_data_rst", tag, d), 128'(o_od[d]), 128'(0));
        check_all(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r;
        is_skid = '{1'b1, 1'b0, 1'b1};
        mask[0] = '1;
        mask[1] = '1;
        mask[2] = word_t'(1);
        idle_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("reset");

        for (int v = 1; v <= 3; v++) begin
            drive(0, 1'b1, word_t'(v), 1'b1);
            step("stream");
        end
        idle_all();
        step("stream_tail");
        step("stream_idle");

        drive(0, 1'b1, word_t'('hA), 1'b0);  step("bp_a");
        drive(0, 1'b1, word_t'('hB), 1'b0);  step("bp_b");
        drive(0, 1'b1, word_t'('hD), 1'b0);  step("bp_hold1");
        step("bp_hold2");
        drive(0, 1'b0, '0, 1'b1);
        step("bp_rel1");
        step("bp_rel2");
        step("bp_rel3");

        drive(1, 1'b1, word_t'('h9), 1'b0);  step("s0_fill");
        drive(1, 1'b1, word_t'('hC), 1'b0);  step("s0_full");
        drive(1, 1'b1, word_t'('hC), 1'b1);  step("s0_reload");
        drive(1, 1'b0, '0, 1'b1);
        step("s0_out");
        step("s0_idle");

        drive(0, 1'b1, word_t'('h11), 1'b0); step("fl_a");
        drive(0, 1'b1, word_t'('h22), 1'b0); step("fl_b");
        drive(0, 1'b1, word_t'('h77), 1'b0);
        flush = 1'b1;
        step("fl_skid");
        flush = 1'b0;
        idle_all();
        repeat (3) step("fl_after");
        drive(0, 1'b1, word_t'('h33), 1'b1); step("fl_full_a");
        drive(0, 1'b1, word_t'('h44), 1'b1);
        drive(1, 1'b1, word_t'('h45), 1'b1);
        flush = 1'b1;
        step("fl_full");
        flush = 1'b0;
        idle_all();
        repeat (3) step("fl_full_after");

        drive(0, 1'b1, word_t'('hA1), 1'b0); step("rm_a");
        drive(0, 1'b1, word_t'('hA2), 1'b0); step("rm_b");
        rst = 1'b1;
        step("rm_rst");
        rst = 1'b0;
        idle_all();
        check_reset_vals("rm_vals");
        drive(0, 1'b1, word_t'('h5), 1'b1);  step("rm_push");
        idle_all();
        step("rm_out");
        step("rm_idle");

        for (int c = 0; c < 10000; c++) begin
            for (int d = 0; d < ND; d++) begin
                r = {$urandom, $urandom, $urandom, $urandom};
                drive(d, ($urandom_range(3, 0) != 0), r[MEMWB_W-1:0], ($urandom_range(3, 0) != 0));
            end
            flush = ($urandom_range(63, 0) == 0);
            rst   = ($urandom_range(1023, 0) == 0);
            step("rand");
        end
        flush = 1'b0;
        rst   = 1'b0;
        idle_all();
        repeat (4) step("drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
